// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: counter and FSM types shared by the branch predictors
package branch_predictor_pkg;
  typedef enum logic [1:0] {SNT, WNT, WT, ST} ctr_t;
  typedef enum logic {BP_INIT, BP_RUN} bp_state_t;
  localparam ctr_t BP_INIT_VAL = WNT;
endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// bp_sat_ctr: next state of one 2-bit saturating direction counter
module bp_sat_ctr
  import branch_predictor_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);
  always_comb
    nxt = taken ? (cur == ST ? ST : ctr_t'(cur + 2'd1)) : (cur == SNT ? SNT : ctr_t'(cur - 2'd1));
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal direction predictor with init sweep, training and mispredict statistics
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lu_valid,
  input  logic [PC_W-1:0] lu_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            up_valid,
  input  logic [PC_W-1:0] up_pc,
  input  logic            up_pred_taken,
  input  logic            bcomp,
  output logic            mispredict,
  output logic            ready,
  input  logic            clr_stats,
  output logic [31:0]     br_cnt,
  output logic [31:0]     miss_cnt
);
  localparam int N = 2 ** IDX_W;
  ctr_t tbl [N];
  bp_state_t state, state_nxt;
  logic [IDX_W-1:0] ptr, lu_idx, up_idx, wr_idx;
  ctr_t rd_ctr, up_ctr, up_nxt, wr_val;
  logic wr_en, acc, miss;
  logic unused_pc;
  assign lu_idx = lu_pc[IDX_W+1:2];
  assign up_idx = up_pc[IDX_W+1:2];
  assign unused_pc = ^{lu_pc[PC_W-1:IDX_W+2], lu_pc[1:0], up_pc[PC_W-1:IDX_W+2], up_pc[1:0]};
  assign rd_ctr = tbl[lu_idx];
  assign up_ctr = tbl[up_idx];
  bp_sat_ctr u_ctr (.cur(up_ctr), .taken(bcomp), .nxt(up_nxt));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BP_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr + IDX_W'(state == BP_INIT);
    end
  end
  always_comb
    state_nxt = (state == BP_INIT && ptr == '1) ? BP_RUN : state;
  // the init sweep owns the write port until the table is fully seeded
  always_comb begin
    ready  = state == BP_RUN;
    acc    = up_valid & ready;
    miss   = acc & (up_pred_taken ^ bcomp);
    wr_en  = ready ? up_valid : 1'b1;
    wr_idx = ready ? up_idx : ptr;
    wr_val = ready ? up_nxt : BP_INIT_VAL;
  end
  always_ff @(posedge clk)
    if (wr_en) tbl[wr_idx] <= wr_val;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      mispredict <= 1'b0;
      br_cnt     <= '0;
      miss_cnt   <= '0;
    end else begin
      pred_valid <= lu_valid;
      if (lu_valid) pred_taken <= ready & rd_ctr[1];
      mispredict <= miss;
      br_cnt     <= clr_stats ? '0 : br_cnt + 32'(acc);
      miss_cnt   <= clr_stats ? '0 : miss_cnt + 32'(miss);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor
module tb_branch_predictor;
  logic        clk = 1'b0, rst = 1'b1;
  logic        lu_valid = 1'b0, up_valid = 1'b0, up_pred_taken = 1'b0, bcomp = 1'b0, clr_stats = 1'b0;
  logic [31:0] lu_pc = '0, up_pc = '0;
  logic        pred_valid, pred_taken, mispredict, ready;
  logic [31:0] br_cnt, miss_cnt;
  int n_chk = 0, n_fail = 0;

  branch_predictor #(.IDX_W(6), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .lu_valid(lu_valid), .lu_pc(lu_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .up_valid(up_valid), .up_pc(up_pc), .up_pred_taken(up_pred_taken), .bcomp(bcomp),
    .mispredict(mispredict), .ready(ready), .clr_stats(clr_stats),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic exp, input string nm);
    lu_valid = 1'b1; lu_pc = pc;
    tick();
    lu_valid = 1'b0;
    n_chk++;
    if (pred_valid !== 1'b1 || pred_taken !== exp) begin
      n_fail++;
      $display("FAIL %s: valid=%b taken=%b, expected valid=1 taken=%b", nm, pred_valid, pred_taken, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic pt, input logic bc);
    up_valid = 1'b1; up_pc = pc; up_pred_taken = pt; bcomp = bc;
    tick();
    up_valid = 1'b0;
  endtask

  task automatic test_reset;
    tick(); tick();
    n_chk++;
    if ({pred_valid, pred_taken, mispredict, ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 0000", {pred_valid, pred_taken, mispredict, ready});
    end
    n_chk++;
    if (br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stats: br=%0h miss=%0h, expected 0 0", br_cnt, miss_cnt);
    end
  endtask

  task automatic test_init;
    lu_valid = 1'b1; lu_pc = 32'h100;
    up_valid = 1'b1; up_pc = 32'h100; up_pred_taken = 1'b0; bcomp = 1'b1;
    rst = 1'b0;
    n_chk++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL init_ready0: got %b, expected 0", ready); end
    for (int i = 1; i <= 64; i++) begin
      tick();
      n_chk++;
      if (ready !== (i == 64)) begin
        n_fail++; $display("FAIL init_ready cycle %0d: got %b, expected %b", i, ready, i == 64);
      end
      n_chk++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
        n_fail++; $display("FAIL init_pred cycle %0d: valid=%b taken=%b, expected 1 0", i, pred_valid, pred_taken);
      end
      n_chk++;
      if (mispredict !== 1'b0 || br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
        n_fail++; $display("FAIL init_ignore cycle %0d: mis=%b br=%0h miss=%0h, expected 0 0 0", i, mispredict, br_cnt, miss_cnt);
      end
    end
    up_valid = 1'b0; lu_valid = 1'b0;
    look(32'h100, 1'b0, "init_entry0");
  endtask

  task automatic test_mispredict;
    upd(32'h80, 1'b0, 1'b1);
    n_chk++;
    if (mispredict !== 1'b1 || br_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      n_fail++; $display("FAIL mis_pulse: mis=%b br=%0h miss=%0h, expected 1 1 1", mispredict, br_cnt, miss_cnt);
    end
    tick();
    n_chk++;
    if (mispredict !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle: got %b, expected 0", mispredict); end
    upd(32'h80, 1'b1, 1'b1);
    n_chk++;
    if (mispredict !== 1'b0 || br_cnt !== 32'd2 || miss_cnt !== 32'd1) begin
      n_fail++; $display("FAIL mis_match: mis=%b br=%0h miss=%0h, expected 0 2 1", mispredict, br_cnt, miss_cnt);
    end
  endtask

  task automatic test_training;
    upd(32'h40, 1'b0, 1'b1);
    look(32'h40, 1'b1, "train_wt");
    tick();
    n_chk++;
    if (pred_valid !== 1'b0 || pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL pred_hold: valid=%b taken=%b, expected 0 1", pred_valid, pred_taken);
    end
    upd(32'h40, 1'b1, 1'b1);
    look(32'h40, 1'b1, "train_st");
    upd(32'h40, 1'b1, 1'b1);
    look(32'h40, 1'b1, "train_st_sat");
    upd(32'h40, 1'b1, 1'b0);
    look(32'h40, 1'b1, "train_down_wt");
    upd(32'h40, 1'b1, 1'b0);
    look(32'h40, 1'b0, "train_down_wnt");
    upd(32'h40, 1'b0, 1'b0);
    upd(32'h40, 1'b0, 1'b0);
    upd(32'h40, 1'b0, 1'b1);
    look(32'h40, 1'b0, "train_snt_sat");
  endtask

  task automatic test_collision;
    lu_valid = 1'b1; lu_pc = 32'h40;
    upd(32'h40, 1'b0, 1'b1);
    lu_valid = 1'b0;
    n_chk++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL collide_old: valid=%b taken=%b, expected 1 0", pred_valid, pred_taken);
    end
    look(32'h40, 1'b1, "collide_new");
    look(32'h140, 1'b1, "alias_read");
    upd(32'h140, 1'b1, 1'b0);
    look(32'h40, 1'b0, "alias_write");
  endtask

  task automatic test_back_to_back;
    logic [31:0] pcs [4];
    logic        exp [4];
    pcs = '{32'h80, 32'h40, 32'hC0, 32'h80};
    exp = '{1'b1, 1'b0, 1'b0, 1'b1};
    lu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lu_pc = pcs[i];
      tick();
      n_chk++;
      if (pred_valid !== 1'b1 || pred_taken !== exp[i]) begin
        n_fail++; $display("FAIL b2b[%0d]: valid=%b taken=%b, expected 1 %b", i, pred_valid, pred_taken, exp[i]);
      end
    end
    lu_valid = 1'b0;
  endtask

  task automatic test_stats_edges;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    n_chk++;
    if (br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++; $display("FAIL clr: br=%0h miss=%0h, expected 0 0", br_cnt, miss_cnt);
    end
    force dut.miss_cnt = 32'hFFFF_FFFF;
    force dut.br_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.miss_cnt;
    release dut.br_cnt;
    tick();
    n_chk++;
    if (br_cnt !== 32'hFFFF_FFFE || miss_cnt !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL preload: br=%0h miss=%0h, expected fffffffe ffffffff", br_cnt, miss_cnt);
    end
    upd(32'h100, 1'b1, 1'b0);
    n_chk++;
    if (mispredict !== 1'b1 || br_cnt !== 32'hFFFF_FFFF || miss_cnt !== 32'd0) begin
      n_fail++; $display("FAIL miss_wrap: mis=%b br=%0h miss=%0h, expected 1 ffffffff 0", mispredict, br_cnt, miss_cnt);
    end
    upd(32'h100, 1'b0, 1'b0);
    n_chk++;
    if (mispredict !== 1'b0 || br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++; $display("FAIL br_wrap: mis=%b br=%0h miss=%0h, expected 0 0 0", mispredict, br_cnt, miss_cnt);
    end
    upd(32'h100, 1'b0, 1'b0);
    clr_stats = 1'b1;
    upd(32'h100, 1'b1, 1'b0);
    clr_stats = 1'b0;
    n_chk++;
    if (mispredict !== 1'b1 || br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++; $display("FAIL clr_priority: mis=%b br=%0h miss=%0h, expected 1 0 0", mispredict, br_cnt, miss_cnt);
    end
  endtask

  task automatic test_reset_mid;
    lu_valid = 1'b1; lu_pc = 32'h80;
    upd(32'h80, 1'b0, 1'b1);
    n_chk++;
    if (pred_taken !== 1'b1 || mispredict !== 1'b1 || br_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      n_fail++; $display("FAIL pre_reset: taken=%b mis=%b br=%0h miss=%0h, expected 1 1 1 1", pred_taken, mispredict, br_cnt, miss_cnt);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({pred_valid, pred_taken, mispredict, ready} !== 4'b0000 || br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: flags=%b br=%0h miss=%0h, expected 0000 0 0", {pred_valid, pred_taken, mispredict, ready}, br_cnt, miss_cnt);
    end
    tick();
    n_chk++;
    if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL drop_inflight: valid=%b, expected 0", pred_valid); end
    lu_valid = 1'b0;
    rst = 1'b0;
    repeat (64) tick();
    n_chk++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reinit_ready: got %b, expected 1", ready); end
    look(32'h80, 1'b0, "reinit_wnt");
  endtask

  initial begin
    test_reset();
    test_init();
    test_mispredict();
    test_training();
    test_collision();
    test_back_to_back();
    test_stats_edges();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Bimodal branch direction predictor. It sits at the fetch end of the branch path and is the prediction side of the branch comparator in execute.
- Fetch looks up a PC and gets a taken/not-taken guess one cycle later.
- Execute returns the resolved outcome (bcomp) with the guess that was used. The block trains its 2-bit counters, flags mispredicts and keeps statistics.

Parameters:
IDX_W, 6, log2 of table entries (64 entries of 2 bits each)
PC_W, 32, program counter width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
lu_valid  input  1  fetch lookup request this cycle
lu_pc  input  PC_W  PC of the instruction being fetched
pred_valid  output  1  prediction result valid (one cycle after lu_valid)
pred_taken  output  1  predicted direction for the previous lookup
up_valid  input  1  execute resolved a conditional branch this cycle
up_pc  input  PC_W  PC of the resolved branch
up_pred_taken  input  1  prediction that was used for this branch
bcomp  input  1  actual outcome from the branch comparator (1 = taken)
mispredict  output  1  registered; high one cycle after up_valid when up_pred_taken != bcomp
ready  output  1  table initialisation complete
clr_stats  input  1  synchronous clear of the statistics counters
br_cnt  output  32  number of accepted updates
miss_cnt  output  32  number of mispredicts

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: pred_valid=0, pred_taken=0, mispredict=0, ready=0, br_cnt=0, miss_cnt=0, FSM=INIT, sweep pointer=0.
- Index: idx = pc[IDX_W+1:2], the word-aligned PC bits. Upper bits are ignored, so aliasing is allowed.
- Counter encoding (ctr_t): SNT=00, WNT=01, WT=10, ST=11. The predicted direction is ctr[1].
- FSM INIT:
  - Writes WNT to entry[ptr] each cycle and increments ptr.
  - After entry 2^IDX_W-1 is written, moves to RUN. ready rises in the first RUN cycle, so INIT lasts exactly 2^IDX_W cycles after rst deasserts.
  - Lookups during INIT are still answered: pred_valid=1, pred_taken=0.
  - up_valid during INIT is ignored: no table write, no counters change, mispredict=0.
- FSM RUN: stays in RUN until rst. There is no software re-init.
- Lookup timing: a lookup at cycle N gives pred_valid=1 and pred_taken=ctr[idx(lu_pc)][1] at cycle N+1. With lu_valid=0, pred_valid=0 at N+1 and pred_taken holds its last value. Back-to-back lookups are supported, one per cycle.
- Update (RUN, up_valid=1):
  - bcomp=1 increments the counter, saturating at ST.
  - bcomp=0 decrements the counter, saturating at SNT.
  - The write takes effect at the clock edge.
- Same-index collision: a lookup and an update to the same index in the same cycle returns the pre-update value. There is no bypass. A lookup one cycle later sees the new value.
- mispredict:
  - Registered: mispredict = up_valid & ready & (up_pred_taken ^ bcomp), visible the next cycle.
  - High for exactly one cycle per mispredicted update.
- Statistics:
  - br_cnt increments by 1 per accepted update. miss_cnt increments by 1 per mispredicted accepted update.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
  - clr_stats has priority over an increment in the same cycle: the result is 0.
- Reset mid-operation:
  - All outputs take their reset values immediately.
  - The table contents are don't-care until the INIT sweep rewrites them.
  - A lookup in flight at reset is dropped: pred_valid stays 0.

Decomposition:
- pkg_cpu_types gains:
  - typedef enum logic [1:0] ctr_t {SNT, WNT, WT, ST};
  - typedef enum logic bp_state_t {BP_INIT, BP_RUN};
  - localparam ctr_t BP_INIT_VAL = WNT.
- Sub-module bp_sat_ctr: combinational next-state for one 2-bit saturating counter, from the current ctr_t and the outcome. It is reused by any later predictor (for example gshare).
- The table is a register array inside branch_predictor with one read port and one write port. The INIT sweep and the update share the write port through a mux selected by FSM state.

Test Plan:
- Init: deassert rst, then lookup pc 0x100 in every cycle -> pred_taken=0 throughout. ready=0 for cycles 0..63, ready=1 at cycle 64.
- Training: 2 updates to pc 0x40 with bcomp=1 -> a lookup after each gives taken=1 after the 1st (WNT->WT) and stays taken=1 after the 2nd (ST). A 3rd taken update stays ST. One bcomp=0 then gives WT (taken=1); a 2nd gives WNT (taken=0).
- Mispredict and stats: up_pred_taken=0, bcomp=1 at cycle N -> mispredict=1 at N+1 only, br_cnt=1, miss_cnt=1. A matching update -> br_cnt=2, miss_cnt=1, no pulse.
- Collision and aliasing:
  - Same cycle, lookup and update (bcomp=1) pc 0x40 from WNT -> pred_taken=0. The next lookup gives 1.
  - pc 0x140 aliases 0x40 at IDX_W=6 and returns the same counter.
- Stats edges: force miss_cnt toward wrap via 0xFFFFFFFF updates (or a bench backdoor), then one more mispredict -> 0. clr_stats together with up_valid -> both counters 0.
- Reset mid-run: assert rst while the counter at 0x40 is ST and a lookup is in flight -> pred_valid=0, ready=0, stats=0. After re-INIT, pc 0x40 predicts not-taken (WNT).
